// File: rtl/ramp_sequencer.sv
// Per-channel DAC envelope controller: linear ramp-up / hold / ramp-down amplitude
// factor taken from the top bits of a saturating phase accumulator.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a ramp-up edge; factor 0 (full scale if bypassed)
// UP    | accumulating ramp_inc towards full scale
// HOLD  | full scale, waiting for a ramp-down edge
// DOWN  | subtracting ramp_inc towards zero
// DONE  | ramp finished, factor 0; a new ramp-up edge re-arms
module ramp_sequencer #(
    parameter int unsigned FACTOR_WIDTH = 16,
    parameter int unsigned ACC_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    enable_ramping,
    input  logic                    start_ramp_up,
    input  logic                    start_ramp_down,
    input  logic                    seq_ramp_down,
    input  logic [ACC_WIDTH-1:0]    ramp_inc,
    output logic [FACTOR_WIDTH-1:0] ramp_factor,
    output logic [2:0]              ramp_state,
    output logic                    ramp_busy,
    output logic                    ramp_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP   = 3'd1,
        HOLD = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_FULL = '1;
    localparam logic [ACC_WIDTH-1:0] ACC_ZERO = '0;

    state_t               state;
    state_t               state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic                 down_pending;
    logic                 down_pending_nxt;
    logic                 start_ramp_up_q;
    logic                 dn_q;
    logic                 dn;
    logic                 up_edge;
    logic                 dn_edge;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH:0]   acc_diff;

    // Register and sequencer ramp-down requests share one edge detector.
    assign dn      = start_ramp_down | seq_ramp_down;
    assign up_edge = start_ramp_up & ~start_ramp_up_q;
    assign dn_edge = dn & ~dn_q;

    // One extra bit exposes carry on the way up and borrow on the way down.
    assign acc_sum  = {1'b0, acc} + {1'b0, ramp_inc};
    assign acc_diff = {1'b0, acc} - {1'b0, ramp_inc};

    always_comb begin
        state_nxt        = state;
        acc_nxt          = acc;
        down_pending_nxt = down_pending;
        if (!enable_ramping) begin
            state_nxt        = IDLE;
            acc_nxt          = ACC_FULL;
            down_pending_nxt = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    acc_nxt          = ACC_ZERO;
                    down_pending_nxt = 1'b0;
                    if (up_edge) begin
                        state_nxt        = UP;
                        down_pending_nxt = dn_edge;
                    end
                end
                UP: begin
                    down_pending_nxt = down_pending | dn_edge;
                    if ((ramp_inc == ACC_ZERO) || acc_sum[ACC_WIDTH] ||
                        (acc_sum[ACC_WIDTH-1:0] == ACC_FULL)) begin
                        acc_nxt          = ACC_FULL;
                        state_nxt        = (down_pending | dn_edge) ? DOWN : HOLD;
                        down_pending_nxt = 1'b0;
                    end else begin
                        acc_nxt = acc_sum[ACC_WIDTH-1:0];
                    end
                end
                HOLD: begin
                    acc_nxt = ACC_FULL;
                    if (dn_edge) begin
                        state_nxt = DOWN;
                    end
                end
                DOWN: begin
                    if ((ramp_inc == ACC_ZERO) || acc_diff[ACC_WIDTH] ||
                        (acc_diff[ACC_WIDTH-1:0] == ACC_ZERO)) begin
                        acc_nxt   = ACC_ZERO;
                        state_nxt = DONE;
                    end else begin
                        acc_nxt = acc_diff[ACC_WIDTH-1:0];
                    end
                end
                default: begin
                    state_nxt        = IDLE;
                    acc_nxt          = ACC_ZERO;
                    down_pending_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= IDLE;
            acc             <= ACC_ZERO;
            down_pending    <= 1'b0;
            start_ramp_up_q <= 1'b0;
            dn_q            <= 1'b0;
            ramp_busy       <= 1'b0;
            ramp_done       <= 1'b0;
        end else begin
            state           <= state_nxt;
            acc             <= acc_nxt;
            down_pending    <= down_pending_nxt;
            start_ramp_up_q <= start_ramp_up;
            dn_q            <= dn;
            ramp_busy       <= (state_nxt == UP) || (state_nxt == DOWN);
            ramp_done       <= (state_nxt == DONE);
        end
    end

    assign ramp_factor = acc[ACC_WIDTH-1 -: FACTOR_WIDTH];
    assign ramp_state  = state;

endmodule

// File: tb/tb_ramp_sequencer.sv
// Bench for ramp_sequencer: vector table for instant ramps and bypass, plus
// hand-written sequences for full ramps, queued ramp-down and async reset.
module tb_ramp_sequencer;
    localparam int FW = 16;
    localparam int AW = 32;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UP   = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [AW-1:0] INC16 = 32'h1000_0000;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          enable_ramping;
    logic          start_ramp_up;
    logic          start_ramp_down;
    logic          seq_ramp_down;
    logic [AW-1:0] ramp_inc;
    logic [FW-1:0] ramp_factor;
    logic [2:0]    ramp_state;
    logic          ramp_busy;
    logic          ramp_done;

    always #5 clk = ~clk;

    ramp_sequencer #(.FACTOR_WIDTH(FW), .ACC_WIDTH(AW)) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .enable_ramping  (enable_ramping),
        .start_ramp_up   (start_ramp_up),
        .start_ramp_down (start_ramp_down),
        .seq_ramp_down   (seq_ramp_down),
        .ramp_inc        (ramp_inc),
        .ramp_factor     (ramp_factor),
        .ramp_state      (ramp_state),
        .ramp_busy       (ramp_busy),
        .ramp_done       (ramp_done)
    );

    typedef struct {
        logic          en;
        logic          up;
        logic          dn;
        logic          sq;
        logic [AW-1:0] inc;
        logic [2:0]    st;
        logic [FW-1:0] fac;
        logic          busy;
        logic          done;
    } vec_t;

    typedef struct {
        string         tag;
        logic [2:0]    st;
        logic [FW-1:0] fac;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic en, up, dn, sq, input logic [AW-1:0] inc,
                                input logic [2:0] st, input logic [FW-1:0] fac,
                                input logic busy, done);
        vec_t v;
        v.en = en; v.up = up; v.dn = dn; v.sq = sq; v.inc = inc;
        v.st = st; v.fac = fac; v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_now(input string tag, input logic [2:0] st, input logic [FW-1:0] fac,
                             input logic busy, input logic done);
        check1({tag, ".state"}, {29'd0, ramp_state}, {29'd0, st});
        check1({tag, ".factor"}, {16'd0, ramp_factor}, {16'd0, fac});
        check1({tag, ".busy"}, {31'd0, ramp_busy}, {31'd0, busy});
        check1({tag, ".done"}, {31'd0, ramp_done}, {31'd0, done});
    endtask

    // Inputs are already driven; queue the expectation, advance one edge, compare.
    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [FW-1:0] fac,
                              input logic busy, input logic done);
        exp_t e;
        e.tag = tag; e.st = st; e.fac = fac; e.busy = busy; e.done = done;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check1({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_now(e.tag, e.st, e.fac, e.busy, e.done);
        end
    endtask

    // Accumulating steps 1..16 after entry to UP; optional ramp-down edge mid-ramp.
    task automatic ramp_up_rest(input string tag, input int dn_at, input logic pend);
        logic [FW-1:0] f;
        start_ramp_up = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            if (dn_at != 0 && i == dn_at) start_ramp_down = 1'b1;
            if (dn_at != 0 && i == dn_at + 2) start_ramp_down = 1'b0;
            f = 16'(i * 32'h1000);
            expect_cyc($sformatf("%s.up%0d", tag, i), S_UP, f, 1'b1, 1'b0);
        end
        if (pend) expect_cyc({tag, ".full_to_down"}, S_DOWN, 16'hFFFF, 1'b1, 1'b0);
        else      expect_cyc({tag, ".full_to_hold"}, S_HOLD, 16'hFFFF, 1'b0, 1'b0);
    endtask

    task automatic ramp_down_rest(input string tag);
        logic [FW-1:0] f;
        for (int j = 1; j <= 15; j++) begin
            f = 16'(32'hFFFF - j * 32'h1000);
            expect_cyc($sformatf("%s.dn%0d", tag, j), S_DOWN, f, 1'b1, 1'b0);
        end
        expect_cyc({tag, ".done"}, S_DONE, 16'h0000, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[14];
        // en up dn sq inc | state factor busy done
        tbl[0]  = mk(1, 0, 0, 0, 0, S_IDLE, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 0, S_UP,   16'h0000, 1, 0);
        tbl[2]  = mk(1, 1, 0, 0, 0, S_HOLD, 16'hFFFF, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, S_HOLD, 16'hFFFF, 0, 0);
        tbl[4]  = mk(1, 0, 1, 0, 0, S_DOWN, 16'hFFFF, 1, 0);
        tbl[5]  = mk(1, 0, 1, 0, 0, S_DONE, 16'h0000, 0, 1);
        tbl[6]  = mk(1, 1, 1, 0, 0, S_UP,   16'h0000, 1, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0, S_HOLD, 16'hFFFF, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, S_IDLE, 16'hFFFF, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0, S_IDLE, 16'hFFFF, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 0, S_IDLE, 16'hFFFF, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, S_IDLE, 16'h0000, 0, 0);
        tbl[12] = mk(1, 0, 0, 1, 0, S_IDLE, 16'h0000, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, S_IDLE, 16'h0000, 0, 0);

        aresetn = 1'b0; enable_ramping = 1'b1; start_ramp_up = 1'b0;
        start_ramp_down = 1'b0; seq_ramp_down = 1'b0; ramp_inc = '0;
        #2;
        check_now("reset", S_IDLE, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 14; k++) begin
            enable_ramping  = tbl[k].en;
            start_ramp_up   = tbl[k].up;
            start_ramp_down = tbl[k].dn;
            seq_ramp_down   = tbl[k].sq;
            ramp_inc        = tbl[k].inc;
            expect_cyc($sformatf("vec%0d", k), tbl[k].st, tbl[k].fac, tbl[k].busy, tbl[k].done);
        end

        // Full ramp up, hold, sequencer ramp-down; held up request must not restart.
        ramp_inc = INC16;
        start_ramp_up = 1'b1;
        expect_cyc("a.enter_up", S_UP, 16'h0000, 1'b1, 1'b0);
        ramp_up_rest("a", 0, 1'b0);
        expect_cyc("a.hold", S_HOLD, 16'hFFFF, 1'b0, 1'b0);
        start_ramp_up = 1'b1;
        expect_cyc("a.hold_up_ignored", S_HOLD, 16'hFFFF, 1'b0, 1'b0);
        seq_ramp_down = 1'b1;
        expect_cyc("a.enter_down", S_DOWN, 16'hFFFF, 1'b1, 1'b0);
        ramp_down_rest("a");
        expect_cyc("a.done_held_up", S_DONE, 16'h0000, 1'b0, 1'b1);
        seq_ramp_down = 1'b0;
        start_ramp_up = 1'b0;
        expect_cyc("a.done_up_low", S_DONE, 16'h0000, 1'b0, 1'b1);
        start_ramp_up = 1'b1;
        expect_cyc("b.rearm", S_UP, 16'h0000, 1'b1, 1'b0);

        // Ramp-down requested mid-ramp: completes to full scale, no HOLD cycle.
        ramp_up_rest("b", 5, 1'b1);
        ramp_down_rest("b");

        // Bypass mid-ramp, requests ignored while bypassed, re-enable clears factor.
        start_ramp_up = 1'b1;
        expect_cyc("c.enter_up", S_UP, 16'h0000, 1'b1, 1'b0);
        start_ramp_up = 1'b0;
        for (int i = 1; i <= 3; i++)
            expect_cyc($sformatf("c.up%0d", i), S_UP, 16'(i * 32'h1000), 1'b1, 1'b0);
        enable_ramping = 1'b0;
        expect_cyc("c.bypass", S_IDLE, 16'hFFFF, 1'b0, 1'b0);
        start_ramp_up = 1'b1;
        expect_cyc("c.bypass_up", S_IDLE, 16'hFFFF, 1'b0, 1'b0);
        seq_ramp_down = 1'b1;
        expect_cyc("c.bypass_dn", S_IDLE, 16'hFFFF, 1'b0, 1'b0);
        start_ramp_up = 1'b0; seq_ramp_down = 1'b0;
        expect_cyc("c.bypass_quiet", S_IDLE, 16'hFFFF, 1'b0, 1'b0);
        enable_ramping = 1'b1;
        expect_cyc("c.reenable", S_IDLE, 16'h0000, 1'b0, 1'b0);

        // Async reset in DOWN, then simultaneous up+down request.
        ramp_inc = '0;
        start_ramp_up = 1'b1;
        expect_cyc("d.enter_up", S_UP, 16'h0000, 1'b1, 1'b0);
        start_ramp_up = 1'b0;
        expect_cyc("d.instant_full", S_HOLD, 16'hFFFF, 1'b0, 1'b0);
        ramp_inc = INC16;
        expect_cyc("d.hold", S_HOLD, 16'hFFFF, 1'b0, 1'b0);
        start_ramp_down = 1'b1;
        expect_cyc("d.enter_down", S_DOWN, 16'hFFFF, 1'b1, 1'b0);
        expect_cyc("d.dn1", S_DOWN, 16'hEFFF, 1'b1, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check_now("d.async_reset", S_IDLE, 16'h0000, 1'b0, 1'b0);
        start_ramp_down = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check_now("d.after_release", S_IDLE, 16'h0000, 1'b0, 1'b0);
        start_ramp_up = 1'b1; start_ramp_down = 1'b1;
        expect_cyc("e.enter_up", S_UP, 16'h0000, 1'b1, 1'b0);
        start_ramp_down = 1'b0;
        ramp_up_rest("e", 0, 1'b1);
        ramp_down_rest("e");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
